// File: rtl/score_display_ctrl.sv
// Binary score -> BCD (serial double dabble) -> time-shared 7-seg decoder -> HEX registers.
// Optional build macro LEADING_ZERO_BLANK_EN blanks zero digits above the highest nonzero digit.
module score_dd_nibble (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module score_display_ctrl #(
  parameter int SCORE_W = 14,
  parameter int DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [SCORE_W-1:0]    score_in,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            dec_digit,
  input  logic [6:0]            dec_seg,
  output logic [7*DIGITS-1:0]   hex_out
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(SCORE_W + 1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam longint unsigned LIMIT = pow10(DIGITS) - 1;

  typedef enum logic [1:0] {IDLE, CONV, SCAN, DONE} state_t;

  state_t                    state;
  logic [SCORE_W-1:0]        bin;
  logic [DIGITS-1:0][3:0]    bcd;
  logic [DIGITS-1:0][3:0]    bcd_adj;
  logic [DIGITS-1:0][6:0]    hex_r;
  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          idx;
  logic [SCORE_W-1:0]        sat;

  assign hex_out = hex_r;

  always_comb begin
    sat = score_in;
    if ({{(64-SCORE_W){1'b0}}, score_in} > LIMIT) sat = LIMIT[SCORE_W-1:0];
  end

  // add-3 correction per nibble; carries never cross nibble boundaries
  for (genvar i = 0; i < DIGITS; i++) begin : g_nib
    score_dd_nibble u_nib (.d(bcd[i]), .q(bcd_adj[i]));
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lz;
  assign lz[0] = 1'b0;
  for (genvar i = 1; i < DIGITS; i++) begin : g_lz
    assign lz[i] = (bcd[DIGITS-1:i] == '0);
  end
`endif

  always_comb begin
    dec_digit = 4'hF;
    if (state == SCAN) begin
      dec_digit = bcd[idx];
`ifdef LEADING_ZERO_BLANK_EN
      if (lz[idx]) dec_digit = 4'hF;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      bin   <= '0;
      bcd   <= '0;
      cnt   <= '0;
      idx   <= '0;
      hex_r <= '1;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (load) begin
            bin   <= sat;
            bcd   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          cnt        <= cnt + 1'b1;
          if (cnt == CNT_W'(SCORE_W - 1)) begin
            idx   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          hex_r[idx] <= dec_seg;
          idx        <= idx + 1'b1;
          if (idx == IDX_W'(DIGITS - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl with an active-low 7-seg decoder model.
module tb_score_display_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic [13:0] score_in = '0;
  logic        busy, done;
  logic [3:0]  dec_digit;
  logic [6:0]  dec_seg;
  logic [27:0] hex_out;

  int n_pass = 0;
  int n_total = 0;

  score_display_ctrl #(.SCORE_W(14), .DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .score_in(score_in),
    .busy(busy), .done(done), .dec_digit(dec_digit),
    .dec_seg(dec_seg), .hex_out(hex_out)
  );

  always #5 clk = ~clk;

  // decoder model, active-low gfedcba; codes above 9 blank
  always_comb begin
    case (dec_digit)
      4'd0: dec_seg = 7'h40;
      4'd1: dec_seg = 7'h79;
      4'd2: dec_seg = 7'h24;
      4'd3: dec_seg = 7'h30;
      4'd4: dec_seg = 7'h19;
      4'd5: dec_seg = 7'h12;
      4'd6: dec_seg = 7'h02;
      4'd7: dec_seg = 7'h78;
      4'd8: dec_seg = 7'h00;
      4'd9: dec_seg = 7'h10;
      default: dec_seg = 7'h7F;
    endcase
  end

  // Load val at edge k, then watch 30 cycles. extra>1 keeps load high through cycle extra-1.
  task automatic run(input int val, input int extra, output int done_at, output int n_done,
                     output logic [15:0] seq, output logic busy1);
    done_at = -1; n_done = 0; seq = '0; busy1 = 1'b0;
    @(negedge clk);
    score_in = 14'(val);
    load = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) busy1 = busy;
      if (n >= 15 && n <= 18) seq[4*(n-15) +: 4] = dec_digit;
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = n;
      end
      load = (n < extra);
      score_in = 14'($urandom_range(0, 16383));
    end
    load = 1'b0;
  endtask

  task automatic test_reset();
    #12 rst_n = 1'b0;
    #1;
    n_total++; if (hex_out !== 28'hFFFFFFF) $display("FAIL reset_hex got=%h exp=%h", hex_out, 28'hFFFFFFF); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
    n_total++; if (dec_digit !== 4'hF) $display("FAIL reset_dec got=%h exp=F", dec_digit); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_value(input string name, input int val, input logic [15:0] exp_seq,
                            input logic [27:0] exp_hex);
    int da, nd; logic [15:0] sq; logic b1;
    run(val, 1, da, nd, sq, b1);
    n_total++; if (b1 !== 1'b1) $display("FAIL %s_busy got=%b exp=1", name, b1); else n_pass++;
    n_total++; if (sq !== exp_seq) $display("FAIL %s_seq got=%h exp=%h", name, sq, exp_seq); else n_pass++;
    n_total++; if (da !== 19) $display("FAIL %s_done_at got=%0d exp=19", name, da); else n_pass++;
    n_total++; if (nd !== 1) $display("FAIL %s_n_done got=%0d exp=1", name, nd); else n_pass++;
    n_total++; if (hex_out !== exp_hex) $display("FAIL %s_hex got=%h exp=%h", name, hex_out, exp_hex); else n_pass++;
    n_total++; if (busy !== 1'b0 || dec_digit !== 4'hF) $display("FAIL %s_idle got=%b/%h exp=0/F", name, busy, dec_digit); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int da, nd; logic [15:0] sq; logic b1;
    run(2468, 20, da, nd, sq, b1);
    n_total++; if (sq !== 16'h2468) $display("FAIL b2b_seq got=%h exp=2468", sq); else n_pass++;
    n_total++; if (nd !== 1) $display("FAIL b2b_n_done got=%0d exp=1", nd); else n_pass++;
    n_total++; if (da !== 19) $display("FAIL b2b_done_at got=%0d exp=19", da); else n_pass++;
    n_total++; if (hex_out !== {7'h24, 7'h19, 7'h02, 7'h00}) $display("FAIL b2b_hex got=%h exp=%h", hex_out, {7'h24, 7'h19, 7'h02, 7'h00}); else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    score_in = 14'd4321;
    load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++; if (hex_out !== 28'hFFFFFFF) $display("FAIL mid_rst_hex got=%h exp=FFFFFFF", hex_out); else n_pass++;
    n_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL mid_rst_flags got=%b%b exp=00", busy, done); else n_pass++;
    n_total++; if (dec_digit !== 4'hF) $display("FAIL mid_rst_dec got=%h exp=F", dec_digit); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    test_value("after_rst", 5678, 16'h5678, {7'h12, 7'h02, 7'h78, 7'h00});
  endtask

  initial begin
    test_reset();
    test_value("v1234", 1234, 16'h1234, {7'h79, 7'h24, 7'h30, 7'h19});
    test_value("sat12000", 12000, 16'h9999, {7'h10, 7'h10, 7'h10, 7'h10});
    test_value("v9999", 9999, 16'h9999, {7'h10, 7'h10, 7'h10, 7'h10});
`ifdef LEADING_ZERO_BLANK_EN
    test_value("v7", 7, 16'hFFF7, {7'h7F, 7'h7F, 7'h7F, 7'h78});
    test_value("v0", 0, 16'hFFF0, {7'h7F, 7'h7F, 7'h7F, 7'h40});
`else
    test_value("v7", 7, 16'h0007, {7'h40, 7'h40, 7'h40, 7'h78});
    test_value("v0", 0, 16'h0000, {7'h40, 7'h40, 7'h40, 7'h40});
`endif
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
